// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// reads to instruction memory, and queues returned words for decode.
module fetch_unit #(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } entry_t;

  state_t                 state_q;
  logic [AW-1:0]          fetch_pc;
  logic [AW-1:0]          grant_pc;
  entry_t [DEPTH-1:0]     fifo_q;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count_q, count_next;
  logic                   push, pop, has_room;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // Data returning for a redirected read is never queued.
  assign push        = (state_q == S_WAIT) & mem_rvalid & ~redirect;
  assign count_next  = count_q + CW'(push) - CW'(pop);
  assign has_room    = (count_next < CW'(DEPTH));

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = fetch_pc;
  assign instr    = instr_valid ? fifo_q[rd_ptr].data : '0;
  assign instr_pc = instr_valid ? fifo_q[rd_ptr].pc   : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fetch_pc <= RESET_PC;
      grant_pc <= RESET_PC;
      fifo_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      // A read already granted must still drain its response before refetch.
      case (state_q)
        S_WAIT, S_DISCARD: state_q <= mem_rvalid ? S_REQ : S_DISCARD;
        S_REQ:             state_q <= mem_gnt ? S_DISCARD : S_REQ;
        default:           state_q <= S_REQ;
      endcase
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: grant_pc, data: mem_rdata};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_next;
      case (state_q)
        S_IDLE: if (has_room) state_q <= S_REQ;
        S_REQ: if (mem_gnt) begin
          grant_pc <= fetch_pc;
          fetch_pc <= fetch_pc + AW'(1);
          state_q  <= S_WAIT;
        end
        S_WAIT:    if (mem_rvalid) state_q <= has_room ? S_REQ : S_IDLE;
        S_DISCARD: if (mem_rvalid) state_q <= S_REQ;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory returning
// addr+0x1000, a decode-side monitor, and one task per scenario.
module tb_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  int tests = 0;
  int fails = 0;

  int gnt_delay = 0;
  int rv_delay  = 1;
  int addr_changes = 0;
  int req_while_pending = 0;
  logic [AW-1:0] gnt_log[$];
  logic [AW-1:0] pc_log[$];
  logic [DW-1:0] data_log[$];

  bit            pending = 1'b0;
  int            rv_cnt = 0;
  int            req_wait = 0;
  bit            last_ung = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] last_addr = '0;

  // Memory: grant after gnt_delay cycles of request, respond rv_delay cycles later.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (mem_req && pending) req_while_pending++;
      if (last_ung && mem_req && mem_addr !== last_addr) addr_changes++;
      if (pending) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_addr + 16'h1000;
          pending    = 1'b0;
        end
      end
      last_ung = 1'b0;
      if (mem_req && !pending) begin
        if (req_wait >= gnt_delay) begin
          mem_gnt = 1'b1; pending = 1'b1; rv_cnt = rv_delay;
          pend_addr = mem_addr; gnt_log.push_back(mem_addr); req_wait = 0;
        end else begin
          req_wait++; last_ung = 1'b1; last_addr = mem_addr;
        end
      end else if (!mem_req) begin
        req_wait = 0;
      end
    end
  end

  always @(negedge clk)
    if (reset && instr_valid && instr_ready) begin
      pc_log.push_back(instr_pc);
      data_log.push_back(instr);
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0;
    repeat (2) tick();
    gnt_log.delete(); pc_log.delete(); data_log.delete();
    reset = 1'b1;
  endtask

  task automatic wait_consumed(input int n, input int maxc, input string name);
    int c = 0;
    while (pc_log.size() < n && c < maxc) begin tick(); c++; end
    tests++;
    if (pc_log.size() < n) begin
      fails++; $display("FAIL %s: consumed %0d want %0d", name, pc_log.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", mem_req); end
    tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 16'h0) begin fails++; $display("FAIL rst_instr: got %h want 0000", instr); end
    tests++; if (instr_pc !== 16'h0) begin fails++; $display("FAIL rst_pc: got %h want 0000", instr_pc); end
  endtask

  task automatic test_boot();
    instr_ready = 1'b1; gnt_delay = 0; rv_delay = 1;
    do_reset();
    tick(); @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL boot_req: got %b want 1", mem_req); end
    tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL boot_addr: got %h want 0000", mem_addr); end
    tick(); @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL boot_early_valid: got %b want 0", instr_valid); end
    tick(); @(negedge clk);
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL boot_valid: got %b want 1", instr_valid); end
    tests++; if (instr !== 16'h1000) begin fails++; $display("FAIL boot_instr: got %h want 1000", instr); end
    wait_consumed(3, 40, "boot_wait");
    for (int i = 0; i < 3; i++) begin
      tests++; if (pc_log[i] !== 16'(i)) begin fails++; $display("FAIL boot_pc%0d: got %h want %h", i, pc_log[i], 16'(i)); end
      tests++; if (data_log[i] !== 16'(16'h1000 + i)) begin fails++; $display("FAIL boot_data%0d: got %h want %h", i, data_log[i], 16'(16'h1000 + i)); end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0; gnt_delay = 0; rv_delay = 1;
    do_reset();
    repeat (40) tick();
    @(negedge clk);
    tests++; if (gnt_log.size() != DEPTH) begin fails++; $display("FAIL bp_grants: got %0d want %0d", gnt_log.size(), DEPTH); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_req: got %b want 0", mem_req); end
    tests++; if (instr_pc !== 16'h0) begin fails++; $display("FAIL bp_head: got %h want 0000", instr_pc); end
    tick();
    instr_ready = 1'b1;
    wait_consumed(8, 60, "bp_wait");
    for (int i = 0; i < 8; i++) begin
      tests++; if (pc_log[i] !== 16'(i) || data_log[i] !== 16'(16'h1000 + i)) begin
        fails++; $display("FAIL bp_seq%0d: got %h/%h want %h/%h", i, pc_log[i], data_log[i], 16'(i), 16'(16'h1000 + i));
      end
    end
    tests++; if (gnt_log[4] !== 16'h4) begin fails++; $display("FAIL bp_resume: got %h want 0004", gnt_log[4]); end
  endtask

  task automatic test_redirect_wait();
    int n = 0; int start; int ng; bit seen = 1'b0;
    instr_ready = 1'b1; gnt_delay = 0; rv_delay = 3;
    do_reset();
    while (!seen && n < 80) begin
      @(negedge clk);
      if (mem_gnt && mem_addr == 16'h5) seen = 1'b1;
      n++;
    end
    tests++; if (!seen) begin fails++; $display("FAIL rw_grant5: got no grant want grant of 0005"); end
    tick();
    ng = gnt_log.size();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    start = pc_log.size();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: got %b want 0", instr_valid); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rw_discard_req: got %b want 0", mem_req); end
    wait_consumed(start + 1, 60, "rw_wait");
    tests++; if (pc_log[start] !== 16'h0040) begin fails++; $display("FAIL rw_pc: got %h want 0040", pc_log[start]); end
    tests++; if (data_log[start] !== 16'h1040) begin fails++; $display("FAIL rw_data: got %h want 1040", data_log[start]); end
    tests++; if (gnt_log[ng] !== 16'h0040) begin fails++; $display("FAIL rw_next_addr: got %h want 0040", gnt_log[ng]); end
  endtask

  task automatic test_redirect_full_pop();
    int start; int ng;
    instr_ready = 1'b0; gnt_delay = 0; rv_delay = 1;
    do_reset();
    repeat (40) tick();
    ng = gnt_log.size();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    start = pc_log.size();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fp_flush: got %b want 0", instr_valid); end
    tests++; if (mem_addr !== 16'h0080) begin fails++; $display("FAIL fp_addr: got %h want 0080", mem_addr); end
    wait_consumed(start + 1, 40, "fp_wait");
    tests++; if (pc_log[start] !== 16'h0080) begin fails++; $display("FAIL fp_pc: got %h want 0080", pc_log[start]); end
    tests++; if (gnt_log[ng] !== 16'h0080) begin fails++; $display("FAIL fp_next_addr: got %h want 0080", gnt_log[ng]); end
  endtask

  task automatic test_slow_mem();
    instr_ready = 1'b1; gnt_delay = 3; rv_delay = 4;
    do_reset();
    addr_changes = 0; req_while_pending = 0;
    wait_consumed(4, 200, "slow_wait");
    for (int i = 0; i < 4; i++) begin
      tests++; if (pc_log[i] !== 16'(i) || data_log[i] !== 16'(16'h1000 + i)) begin
        fails++; $display("FAIL slow_seq%0d: got %h/%h want %h/%h", i, pc_log[i], data_log[i], 16'(i), 16'(16'h1000 + i));
      end
    end
    tests++; if (addr_changes != 0) begin fails++; $display("FAIL slow_addr_stable: got %0d changes want 0", addr_changes); end
    tests++; if (req_while_pending != 0) begin fails++; $display("FAIL slow_outstanding: got %0d want 0", req_while_pending); end
  endtask

  task automatic test_wrap_async();
    int start; int n = 0; int gseen = 0;
    instr_ready = 1'b1; gnt_delay = 0; rv_delay = 1;
    do_reset();
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    start = pc_log.size();
    wait_consumed(start + 2, 40, "wrap_wait");
    tests++; if (pc_log[start] !== 16'hFFFF || data_log[start] !== 16'h0FFF) begin
      fails++; $display("FAIL wrap_ffff: got %h/%h want ffff/0fff", pc_log[start], data_log[start]);
    end
    tests++; if (pc_log[start+1] !== 16'h0000 || data_log[start+1] !== 16'h1000) begin
      fails++; $display("FAIL wrap_0000: got %h/%h want 0000/1000", pc_log[start+1], data_log[start+1]);
    end
    // Fill the queue a little, then hit reset while a read is outstanding.
    instr_ready = 1'b0; rv_delay = 4;
    while (gseen < 2 && n < 60) begin
      @(negedge clk);
      if (mem_gnt) gseen++;
      n++;
    end
    tests++; if (gseen < 2) begin fails++; $display("FAIL ar_grants: got %0d want 2", gseen); end
    tick();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b want 1", instr_valid); end
    #2 reset = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
      fails++; $display("FAIL ar_outputs: got %b/%h/%h want 0/0000/0000", instr_valid, instr, instr_pc);
    end
    tests++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin
      fails++; $display("FAIL ar_mem: got %b/%h want 0/0000", mem_req, mem_addr);
    end
    tick();
    reset = 1'b1;
    start = pc_log.size();
    instr_ready = 1'b1;
    wait_consumed(start + 1, 60, "ar_wait");
    tests++; if (pc_log[start] !== 16'h0000 || data_log[start] !== 16'h1000) begin
      fails++; $display("FAIL ar_first: got %h/%h want 0000/1000", pc_log[start], data_log[start]);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_wait();
    test_redirect_full_pop();
    test_slow_mem();
    test_wrap_async();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decode/execute datapath. It owns the fetch program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small FIFO. It presents them to decode with a valid/ready handshake, so decode sees the same 16-bit instruction word it splits into opcode/rs1/rs2/rd. A redirect input (branch/jump) flushes the queue and discards any in-flight read.

## Interface
- DEPTH, 4: instruction FIFO entries (power of two, ≥2)
- AW, 16: address / PC width
- DW, 16: instruction width
- RESET_PC, 0: fetch PC after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mem_req  out  1  read request to instruction memory
- mem_addr  out  AW  word address of request (= fetch_pc at all times)
- mem_gnt  in  1  memory accepts request this cycle (mem_req && mem_gnt)
- mem_rvalid  in  1  read data valid; exactly one per granted request, ≥1 cycle after grant
- mem_rdata  in  DW  read data
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  AW  new fetch address
- instr  out  DW  head-of-queue instruction; 0 when instr_valid=0
- instr_pc  out  AW  address of instr; 0 when instr_valid=0
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready

## Operation
- PC is word-addressed: fetch_pc += 1 on each grant; wraps 2^AW−1 → 0.
- At most one outstanding read. FSM states: IDLE, REQ, WAIT, DISCARD.
- IDLE: mem_req=0. → REQ if count_next < DEPTH.
- REQ: mem_req=1, mem_addr stable. On mem_gnt: fetch_pc+1, → WAIT. Else stay.
- WAIT: mem_req=0. On mem_rvalid: push {mem_rdata, fetch_pc−1 captured at grant} into FIFO; → REQ if count_next < DEPTH, else IDLE.
- DISCARD: mem_req=0. On mem_rvalid: drop data, → REQ.
- count_next = count + push − pop. REQ is entered only when a slot is free; count cannot rise while a read is outstanding, so a push never overflows. No push ever occurs when full.
- Redirect (any state, highest priority):
  - FIFO flushed (count=0, pointers reset) and fetch_pc ← redirect_pc on the same edge.
  - A pop in the same cycle is a completed handshake; the entry is then gone via the flush.
  - Next state: DISCARD if in WAIT, or in REQ with mem_gnt this cycle (the granted read is abandoned, not incremented past); stay DISCARD if already DISCARD; otherwise REQ.
  - An ungranted request in REQ is withdrawn; mem_addr changes to redirect_pc next cycle. The memory protocol permits withdrawal before grant.
  - mem_rvalid arriving in the redirect cycle itself while in WAIT/DISCARD is dropped, and the next state is REQ.
- mem_rvalid outside WAIT/DISCARD is a protocol error. It is ignored.

## Timing
- Reset asserted: state IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- First edge after reset release: IDLE→REQ; mem_req=1 in the following cycle.
- Zero-wait memory (gnt in REQ cycle N, rvalid in cycle N+1): instr_valid=1 from cycle N+2; steady throughput 1 instr / 2 cycles.
- Push-to-visible latency: 1 cycle (registered FIFO; instr_valid rises the cycle after the push edge).
- instr/instr_pc/instr_valid are registered/FIFO outputs with no combinational path from instr_ready. mem_req is a state decode with no combinational path from mem_gnt.
- Redirect at edge E: instr_valid=0 in cycle after E. The first instruction from redirect_pc is no earlier than E+3 with zero-wait memory.

## Test plan
- Reset/boot: RESET_PC=0, zero-wait memory returning data=addr+16'h1000, instr_ready=1 → mem_addr sequence 0,1,2,…; decode receives (instr_pc, instr) = (0,1000),(1,1001),(2,1002) in order; instr_valid low during reset.
- Backpressure: instr_ready=0, DEPTH=4 → exactly 4 grants, then mem_req stays 0, count=4. Raise instr_ready → fetch resumes at addr 4, no loss or duplication.
- Redirect in WAIT: grant addr 5, redirect to 16'h0040 before rvalid → rvalid data for addr 5 dropped; next request addr 0x40; first instr_pc seen = 0x40.
- Redirect with full queue plus simultaneous pop: 4 entries queued, instr_ready=1 and redirect=1 same cycle → instr_valid=0 next cycle; next fetch at redirect_pc.
- Slow memory: gnt delayed 3 cycles, rvalid 4 cycles after grant → mem_addr stable while mem_req=1; single outstanding read; order preserved.
- PC wrap and async reset: redirect to 16'hFFFF → fetches 0xFFFF then 0x0000. Assert reset mid-WAIT asynchronously → outputs return to reset values immediately; a late rvalid after reset release is not pushed.
